camera_pixel_reconstruct: RTL and testbench

Front-end stage for each camera path: samples the raw 8-bit camera bus (pclk, hsync, vsync, data) in the system clock domain and assembles byte pairs into 16-bit RGB565 pixels. Each assembled pixel is tagged with its line/column position, and a one-cycle `pixel_valid_out` strobe is raised. That strobe is the event input for the downstream pixel/line event counters. The design instantiates one copy per camera, and the stereo pipeline consumes both outputs.

---
 rtl/camera_pkg.sv | 27 ++
 rtl/camera_pixel_reconstruct_if.sv | 35 +++
 rtl/camera_pixel_reconstruct_sync.sv | 38 +++
 rtl/camera_pixel_reconstruct.sv | 184 ++++++++++++++++++
 tb/tb_camera_pixel_reconstruct.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/camera_pkg.sv
// Shared types for the camera front-end.
// State enum, RGB565 field widths and bus widths.
package camera_pkg;

  typedef enum logic [1:0] {
    VBLANK,
    LINE_WAIT,
    BYTE_HI,
    BYTE_LO
  } cam_state_t;

  localparam int BYTE_W  = 8;
  localparam int RGB_R_W = 5;
  localparam int RGB_G_W = 6;
  localparam int RGB_B_W = 5;
  localparam int PIX_W   = RGB_R_W + RGB_G_W + RGB_B_W;

  // vs, hs and the data byte travel together
  localparam int BUS_W = BYTE_W + 2;

  typedef struct packed {
    logic [RGB_R_W-1:0] r;
    logic [RGB_G_W-1:0] g;
    logic [RGB_B_W-1:0] b;
  } rgb565_t;

endpackage

// File: rtl/camera_pixel_reconstruct_if.sv
// Pixel output bundle of camera_pixel_reconstruct.
// master: valid/data/hcount/vcount/frame_start/overflow out.
interface camera_pixel_reconstruct_if
  import camera_pkg::*;
#(
  parameter int HCOUNT_WIDTH = 11,
  parameter int VCOUNT_WIDTH = 10
);

  logic                    pixel_valid_out;
  logic [PIX_W-1:0]        pixel_data_out;
  logic [HCOUNT_WIDTH-1:0] pixel_hcount_out;
  logic [VCOUNT_WIDTH-1:0] pixel_vcount_out;
  logic                    frame_start_out;
  logic                    overflow_out;

  modport master (
    output pixel_valid_out,
    output pixel_data_out,
    output pixel_hcount_out,
    output pixel_vcount_out,
    output frame_start_out,
    output overflow_out
  );

  modport slave (
    input pixel_valid_out,
    input pixel_data_out,
    input pixel_hcount_out,
    input pixel_vcount_out,
    input frame_start_out,
    input overflow_out
  );

endinterface

// File: rtl/camera_pixel_reconstruct_sync.sv
// N-bit 2-flop synchronizer with registered edge flags.
// Ports: clk_in, rst_n_in, d in; q (delayed), rise, fall out.
module sync_edge_detect #(
  parameter int N = 1
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  logic [N-1:0] s1, s2, s3;
  logic [N-1:0] rise_q, fall_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1     <= '0;
      s2     <= '0;
      s3     <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      s1     <= d;
      s2     <= s1;
      s3     <= s2;
      rise_q <= s2 & ~s3;
      fall_q <= ~s2 & s3;
    end
  end

  // s3 carries the s2 value that the edge flags were computed from
  assign q    = s3;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/camera_pixel_reconstruct.sv
// Camera byte bus to RGB565 pixel assembler with line/column tags.
// Ports: clk_in, rst_n_in, camera_{pclk,hs,vs,d}_in; pix (master).
module camera_pixel_reconstruct
  import camera_pkg::*;
#(
  parameter int HCOUNT_WIDTH = 11,
  parameter int VCOUNT_WIDTH = 10
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              camera_pclk_in,
  input  logic              camera_hs_in,
  input  logic              camera_vs_in,
  input  logic [BYTE_W-1:0] camera_d_in,
  camera_pixel_reconstruct_if.master pix
);

  logic             pclk_q, pclk_rise, pclk_fall;
  logic [BUS_W-1:0] bus_q, bus_rise, bus_fall;
  logic             unused_edges;

  sync_edge_detect #(.N(1)) u_pclk_sync (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .d        (camera_pclk_in),
    .q        (pclk_q),
    .rise     (pclk_rise),
    .fall     (pclk_fall)
  );

  sync_edge_detect #(.N(BUS_W)) u_bus_sync (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .d        ({camera_vs_in, camera_hs_in, camera_d_in}),
    .q        (bus_q),
    .rise     (bus_rise),
    .fall     (bus_fall)
  );

  assign unused_edges = ^{pclk_q, pclk_fall, bus_rise, bus_fall};

  logic              vs, hs;
  logic [BYTE_W-1:0] d;

  assign vs = bus_q[BUS_W-1];
  assign hs = bus_q[BUS_W-2];
  assign d  = bus_q[BYTE_W-1:0];

  cam_state_t              state_q, state_d;
  logic [BYTE_W-1:0]       hi_q, hi_d;
  logic [HCOUNT_WIDTH-1:0] hc_q, hc_d;
  logic [VCOUNT_WIDTH-1:0] vc_q, vc_d;
  logic                    full_q, full_d;
  logic                    arm_q, arm_d;
  logic                    valid_q, valid_d;
  logic                    fs_q, fs_d;
  rgb565_t                 data_q, data_d;
  logic [HCOUNT_WIDTH-1:0] ho_q, ho_d;
  logic [VCOUNT_WIDTH-1:0] vo_q, vo_d;
  logic                    ovf_q, ovf_d;
  logic                    eol;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= VBLANK;
      hi_q    <= '0;
      hc_q    <= '0;
      vc_q    <= '0;
      full_q  <= 1'b0;
      arm_q   <= 1'b0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      data_q  <= '0;
      ho_q    <= '0;
      vo_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      full_q  <= full_d;
      arm_q   <= arm_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
      data_q  <= data_d;
      ho_q    <= ho_d;
      vo_q    <= vo_d;
      ovf_q   <= ovf_d;
    end
  end

  // full_q: the last column has been emitted on this line, so
  // further pixels are dropped. arm_q: vs seen high, so a vs
  // low sample is a genuine falling edge (not a reset artefact).
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    hc_d    = hc_q;
    vc_d    = vc_q;
    full_d  = full_q;
    arm_d   = arm_q;
    valid_d = 1'b0;
    fs_d    = 1'b0;
    data_d  = data_q;
    ho_d    = ho_q;
    vo_d    = vo_q;
    ovf_d   = ovf_q;
    eol     = 1'b0;
    if (pclk_rise) begin
      if (vs && state_q != VBLANK) begin
        state_d = VBLANK;
        hc_d    = '0;
        vc_d    = '0;
        full_d  = 1'b0;
        arm_d   = 1'b1;
      end else begin
        unique case (state_q)
          VBLANK: begin
            hc_d   = '0;
            vc_d   = '0;
            full_d = 1'b0;
            if (vs) begin
              arm_d = 1'b1;
            end else if (arm_q) begin
              state_d = LINE_WAIT;
              fs_d    = 1'b1;
              arm_d   = 1'b0;
            end
          end
          LINE_WAIT: begin
            if (hs) begin
              hi_d    = d;
              state_d = BYTE_LO;
            end
          end
          BYTE_LO: begin
            if (hs) begin
              state_d = BYTE_HI;
              if (full_q) begin
                ovf_d = 1'b1;
              end else begin
                valid_d = 1'b1;
                data_d  = {hi_q, d};
                ho_d    = hc_q;
                vo_d    = vc_q;
                if (hc_q == '1) full_d = 1'b1;
                else hc_d = hc_q + 1'b1;
              end
            end else begin
              eol     = 1'b1;
              state_d = LINE_WAIT;
            end
          end
          BYTE_HI: begin
            if (hs) begin
              hi_d    = d;
              state_d = BYTE_LO;
            end else begin
              eol     = 1'b1;
              state_d = LINE_WAIT;
            end
          end
          default: state_d = VBLANK;
        endcase
      end
    end
    // Lines without a completed pixel leave vcount alone
    if (eol && hc_q != '0) begin
      hc_d   = '0;
      full_d = 1'b0;
      if (vc_q == '1) ovf_d = 1'b1;
      else vc_d = vc_q + 1'b1;
    end
  end

  assign pix.pixel_valid_out  = valid_q;
  assign pix.pixel_data_out   = data_q;
  assign pix.pixel_hcount_out = ho_q;
  assign pix.pixel_vcount_out = vo_q;
  assign pix.frame_start_out  = fs_q;
  assign pix.overflow_out     = ovf_q;

endmodule

// File: tb/tb_camera_pixel_reconstruct.sv
// Bench for camera_pixel_reconstruct (HCOUNT_WIDTH=3).
// Directed scenarios with random bytes against a line-level model.
module tb_camera_pixel_reconstruct;
  import camera_pkg::*;

  localparam int HW   = 3;
  localparam int VW   = 10;
  localparam int HMAX = (1 << HW) - 1;
  localparam int VMAX = (1 << VW) - 1;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    logic [15:0] d;
    int          h;
    int          v;
    int          lat;
  } pix_t;

  logic       clk_in   = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       cam_pclk = 1'b0;
  logic       cam_hs   = 1'b0;
  logic       cam_vs   = 1'b0;
  logic [7:0] cam_d    = 8'h00;

  int   cyc       = 0;
  int   rise_edge = 0;
  int   fs_cnt    = 0;
  int   exp_fs    = 0;
  int   exp_v     = 0;
  logic exp_ovf   = 1'b0;
  int   n_checks  = 0;
  int   n_err     = 0;
  pix_t obs_q[$];
  pix_t exp_q[$];

  camera_pixel_reconstruct_if #(
    .HCOUNT_WIDTH (HW),
    .VCOUNT_WIDTH (VW)
  ) pix ();

  camera_pixel_reconstruct #(
    .HCOUNT_WIDTH (HW),
    .VCOUNT_WIDTH (VW)
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .camera_pclk_in (cam_pclk),
    .camera_hs_in   (cam_hs),
    .camera_vs_in   (cam_vs),
    .camera_d_in    (cam_d),
    .pix            (pix)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (pix.pixel_valid_out === 1'b1)
      obs_q.push_back('{pix.pixel_data_out,
                        int'(pix.pixel_hcount_out),
                        int'(pix.pixel_vcount_out),
                        cyc - rise_edge});
    if (pix.frame_start_out === 1'b1) fs_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // One pclk period: 3 clk_in high, 3 low; rise_edge is the
  // clk_in edge that first captures the high level.
  task automatic pclk_cycle(input logic vs, input logic hs,
                            input logic [7:0] b);
    @(negedge clk_in);
    cam_vs    = vs;
    cam_hs    = hs;
    cam_d     = b;
    cam_pclk  = 1'b1;
    rise_edge = cyc + 1;
    repeat (3) @(negedge clk_in);
    cam_pclk = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic model_line(input bytes_t b);
    int np;
    np = b.size() / 2;
    for (int i = 0; i < np; i++) begin
      if (i <= HMAX) exp_q.push_back('{{b[2*i], b[2*i+1]}, i, exp_v, 3});
      else exp_ovf = 1'b1;
    end
    if (np > 0) begin
      if (exp_v == VMAX) exp_ovf = 1'b1;
      else exp_v++;
    end
  endtask

  task automatic send_line(input bytes_t b);
    foreach (b[i]) pclk_cycle(1'b0, 1'b1, b[i]);
    pclk_cycle(1'b0, 1'b0, 8'h00);
    pclk_cycle(1'b0, 1'b0, 8'h00);
    model_line(b);
  endtask

  task automatic rand_line(input int nbytes);
    bytes_t b;
    for (int i = 0; i < nbytes; i++) b.push_back(8'($urandom));
    send_line(b);
  endtask

  task automatic vblank();
    pclk_cycle(1'b1, 1'b0, 8'h00);
    pclk_cycle(1'b1, 1'b0, 8'h00);
    pclk_cycle(1'b0, 1'b0, 8'h00);
    exp_fs++;
    exp_v = 0;
    chk("frame_start_count", fs_cnt, exp_fs);
  endtask

  task automatic check_pixels(input string tag);
    chk({tag, ".count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk($sformatf("%s.data%0d", tag, i), obs_q[i].d, exp_q[i].d);
      chk($sformatf("%s.h%0d", tag, i), obs_q[i].h, exp_q[i].h);
      chk($sformatf("%s.v%0d", tag, i), obs_q[i].v, exp_q[i].v);
      chk($sformatf("%s.lat%0d", tag, i), obs_q[i].lat, exp_q[i].lat);
    end
    chk({tag, ".overflow"}, pix.overflow_out, exp_ovf);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, pix.pixel_valid_out, 0);
    chk({tag, ".data"}, pix.pixel_data_out, 0);
    chk({tag, ".hcount"}, pix.pixel_hcount_out, 0);
    chk({tag, ".vcount"}, pix.pixel_vcount_out, 0);
    chk({tag, ".frame_start"}, pix.frame_start_out, 0);
    chk({tag, ".overflow"}, pix.overflow_out, 0);
  endtask

  task automatic idle_toggle(input int n);
    for (int i = 0; i < n; i++)
      pclk_cycle(1'b0, 1'(i % 2), 8'($urandom));
  endtask

  initial begin
    bytes_t b;
    int     fs_before;

    // reset held while the camera is already mid-line
    idle_toggle(3);
    check_zero("reset");
    @(negedge clk_in);
    rst_n_in = 1'b1;
    idle_toggle(8);
    chk("post_reset_no_pixels", obs_q.size(), 0);
    chk("post_reset_no_frame_start", fs_cnt, 0);
    obs_q.delete();

    vblank();

    b = '{8'hAB, 8'hCD, 8'h12, 8'h34};
    send_line(b);
    check_pixels("single");
    chk("hold_data", pix.pixel_data_out, 16'h1234);
    chk("hold_h", pix.pixel_hcount_out, 1);

    rand_line(3);
    rand_line(4);
    check_pixels("odd");

    // hs pulse with no pclk rise inside it
    @(negedge clk_in);
    cam_hs = 1'b1;
    @(negedge clk_in);
    cam_hs = 1'b0;
    rand_line(6);
    check_pixels("empty_line");

    // vs rises right after the high byte of the fifth pixel
    b.delete();
    for (int i = 0; i < 9; i++) b.push_back(8'($urandom));
    foreach (b[i]) pclk_cycle(1'b0, 1'b1, b[i]);
    pclk_cycle(1'b1, 1'b1, 8'h5A);
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{{b[2*i], b[2*i+1]}, i, exp_v, 3});
    exp_v = 0;
    pclk_cycle(1'b1, 1'b0, 8'h00);
    check_pixels("vs_abort");
    vblank();
    rand_line(4);
    check_pixels("after_abort");

    for (int n = 0; n < 6; n++) rand_line($urandom_range(0, 12));
    check_pixels("random_lines");

    chk("overflow_before", pix.overflow_out, 0);
    rand_line(20);
    check_pixels("overflow_line");
    rand_line(4);
    check_pixels("overflow_sticky");

    // reset in the middle of a line
    fs_before = fs_cnt;
    for (int i = 0; i < 5; i++) pclk_cycle(1'b0, 1'b1, 8'($urandom));
    #2;
    rst_n_in = 1'b0;
    #1;
    check_zero("mid_reset");
    obs_q.delete();
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_v   = 0;
    idle_toggle(2);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    idle_toggle(8);
    chk("mid_reset_no_pixels", obs_q.size(), 0);
    chk("mid_reset_no_frame_start", fs_cnt, fs_before);
    obs_q.delete();
    vblank();
    rand_line(8);
    check_pixels("after_mid_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
